// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared definitions for the serial pattern generator and the
//               sequence detector that consumes its output. Holds the FSM
//               state encoding and the default bit period so both sides
//               agree on the bit rate.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Clocks per serial bit at 50 MHz -> 2 bits per second.
  localparam int unsigned SEQ_DIV = 25_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : Free-running DIV-cycle divider used to time both the serial
//               bits and the inter-frame gap. Counts while enabled and wraps
//               after DIV cycles.
// Ports       : clk_i   - clock
//               rst_i   - asynchronous active-high reset
//               clr_i   - synchronous clear of the count
//               en_i    - count enable
//               first_o - count is zero (first cycle of a period)
//               tc_o    - terminal count: last enabled cycle of a period
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timer
  import seq_pkg::*;
#(
  parameter int unsigned DIV = SEQ_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic first_o,
  output logic tc_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign first_o = (cnt_q == '0);
  assign tc_o    = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_gen
// Description : Serial pattern generator. A rising edge on start loads pat/len
//               and shifts the pattern out MSB first on x, one bit every DIV
//               clocks. In repeat mode frames are separated by a DIV-cycle
//               low gap and pat/len are re-sampled for each frame.
//               All outputs are registered, so they trail the FSM state by
//               one cycle; the first bit appears two cycles after the edge
//               that sees the start rising edge.
// Ports       : CLOCK_50 - clock          rst      - async active-high reset
//               start    - launch (edge)  rep      - repeat mode
//               pat[W]   - pattern        len[4]   - bits per frame (0/>W = W)
//               x        - serial stream  bit_tick - first cycle of each bit
//               busy     - frame active   done     - non-repeating frame end
// Revision    : 1.0 - initial release
// ============================================================================
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned DIV = SEQ_DIV,
  parameter int unsigned W   = 8
) (
  input  logic         CLOCK_50,
  input  logic         rst,
  input  logic         start,
  input  logic         rep,
  input  logic [W-1:0] pat,
  input  logic [3:0]   len,
  output logic         x,
  output logic         bit_tick,
  output logic         busy,
  output logic         done
);

  localparam int unsigned IW = $clog2(W) + 1;
  localparam int unsigned SW = $clog2(W);

  seq_state_e    state_q, state_d;
  logic          start_d;                // previous-cycle copy of start
  logic          armed_q;                // low for the first cycle after reset
  logic [W-1:0]  pat_q, pat_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          x_q, x_d;
  logic          tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmr_clr;

  logic          w_rise;
  logic [IW-1:0] w_len_eff;
  logic [SW-1:0] w_sel;
  logic          w_tmr_en;
  logic          w_tmr_first;
  logic          w_tmr_tc;

  // armed_q keeps a start held high across reset release from looking like
  // an edge, since start_d comes out of reset at 0.
  assign w_rise = start && !start_d && armed_q;

  always_comb begin
    w_len_eff = IW'(len);
    if (len == 4'd0 || int'(len) > int'(W)) w_len_eff = IW'(W);
  end

  assign w_sel    = SW'(W - 1) - idx_q[SW-1:0];
  assign w_tmr_en = (state_q == SEND) || (state_q == GAP);

  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk_i   (CLOCK_50),
    .rst_i   (rst),
    .clr_i   (tmr_clr),
    .en_i    (w_tmr_en),
    .first_o (w_tmr_first),
    .tc_o    (w_tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    x_d     = 1'b0;
    tick_d  = 1'b0;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;
    tmr_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_rise) state_d = LOAD;
      end
      LOAD: begin
        pat_d   = pat;
        len_d   = w_len_eff;
        idx_d   = '0;
        tmr_clr = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        x_d    = pat_q[w_sel];
        tick_d = w_tmr_first;
        if (w_tmr_tc) begin
          if (idx_q == len_q - IW'(1)) begin
            // Index is left at the last bit rather than wrapping.
            if (rep) begin
              state_d = GAP;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      GAP: begin
        if (w_tmr_tc) begin
          if (rep) begin
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_d <= 1'b0;
      armed_q <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      x_q     <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_d <= start;
      armed_q <= 1'b1;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x        = x_q;
  assign bit_tick = tick_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_gen
// Description : Self-checking bench for seq_gen (DIV=4, W=8). Stimulus pushes
//               expected serial bits (0/1) and done markers (2) into a queue;
//               a monitor pops one entry per bit_tick / done pulse. A small
//               model of the 10010 sequence detector, advanced on bit_tick,
//               checks the detector hit position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

  localparam int DIV = 4;
  localparam int W   = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         rep   = 1'b0;
  logic [W-1:0] pat   = '0;
  logic [3:0]   len   = '0;
  logic         x, bit_tick, busy, done;

  always #5 clk = ~clk;

  seq_gen #(
    .DIV (DIV),
    .W   (W)
  ) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .start    (start),
    .rep      (rep),
    .pat      (pat),
    .len      (len),
    .x        (x),
    .bit_tick (bit_tick),
    .busy     (busy),
    .done     (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int tick_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int det_hit  = 0;
  logic [4:0] det_sr = '0;
  int mon_e;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per bit_tick or done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (bit_tick) begin
        tick_cnt++;
        det_sr = {det_sr[3:0], x};
        if (det_sr == 5'b10010 && det_hit == 0) det_hit = tick_cnt;
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("serial_bit", int'(x), mon_e);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_order", 2, mon_e);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    tick_cnt = 0;
    done_cnt = 0;
    busy_cnt = 0;
    det_hit  = 0;
    det_sr   = '0;
  endtask

  task automatic push_frame(input logic [W-1:0] p, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(int'(p[W-1-i]));
  endtask

  // Raises start after a posedge; returns just after the edge that sees it.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One non-repeating frame; n is the hand-computed number of bits sent.
  task automatic do_frame(input logic [W-1:0] p, input logic [3:0] l, input int n);
    clear_stats();
    pat = p;
    len = l;
    rep = 1'b0;
    push_frame(p, n);
    exp_q.push_back(2);
    pulse_start();
    @(negedge clk);
    chk("busy_after_edge", int'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("busy_in_load", int'(busy), 1);
    chk("x_before_first", int'(x), 0);
    @(posedge clk);
    @(negedge clk);
    chk("first_bit_latency", int'(x), int'(p[W-1]));
    run(n * DIV + 10);
    chk("busy_cycles", busy_cnt, n * DIV + 1);
    chk("tick_count", tick_cnt, n);
    chk("done_count", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(bit_tick), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(3);

    // Basic frame, detector hit on 5th bit
    do_frame(8'b1001_0000, 4'd5, 5);
    chk("detector_hit_bit", det_hit, 5);
    run(3);

    // len=0 and len>W mean full width; len=1 minimum
    do_frame(8'hA5, 4'd0, 8);
    run(3);
    do_frame(8'h3C, 4'd9, 8);
    run(3);
    do_frame(8'h80, 4'd1, 1);
    run(3);

    // Repeat: pat changed during frame 1, rep dropped during frame 2
    clear_stats();
    pat = 8'b1001_0000;
    len = 4'd5;
    rep = 1'b1;
    push_frame(8'b1001_0000, 5);
    push_frame(8'hFF, 5);
    exp_q.push_back(2);
    pulse_start();
    run(4);
    pat = 8'hFF;
    run(18);
    @(negedge clk);
    chk("gap_x_low", int'(x), 0);
    chk("gap_busy", int'(busy), 1);
    run(4);
    @(negedge clk);
    chk("reload_x_low", int'(x), 0);
    run(1);
    @(negedge clk);
    chk("frame2_first_bit", int'(x), 1);
    run(3);
    rep = 1'b0;
    run(30);
    chk("rep_busy_cycles", busy_cnt, 46);
    chk("rep_tick_count", tick_cnt, 10);
    chk("rep_done_count", done_cnt, 1);
    chk("rep_queue_empty", exp_q.size(), 0);
    run(3);

    // rep dropped during the gap: done at end of gap
    clear_stats();
    pat = 8'b1001_0000;
    len = 4'd5;
    rep = 1'b1;
    push_frame(8'b1001_0000, 5);
    exp_q.push_back(2);
    pulse_start();
    run(22);
    rep = 1'b0;
    run(20);
    chk("gapdrop_busy_cycles", busy_cnt, 25);
    chk("gapdrop_tick_count", tick_cnt, 5);
    chk("gapdrop_done_count", done_cnt, 1);
    chk("gapdrop_queue_empty", exp_q.size(), 0);
    run(3);

    // Reset mid-frame with start held high across release
    clear_stats();
    pat = 8'b1001_0000;
    len = 4'd5;
    rep = 1'b0;
    push_frame(8'b1001_0000, 4);
    pulse_start();
    run(15);
    start = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("abort_x", int'(x), 0);
    chk("abort_busy", int'(busy), 0);
    run(2);
    rst = 1'b0;
    run(20);
    chk("held_start_busy", int'(busy), 0);
    chk("abort_done_count", done_cnt, 0);
    chk("abort_tick_count", tick_cnt, 4);
    chk("abort_queue_empty", exp_q.size(), 0);
    start = 1'b0;
    run(2);
    clear_stats();
    push_frame(8'b1001_0000, 5);
    exp_q.push_back(2);
    pulse_start();
    run(30);
    chk("restart_tick_count", tick_cnt, 5);
    chk("restart_done_count", done_cnt, 1);
    chk("restart_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter DIV, default 25_000_000: clocks per serial bit, legal range >= 2.
REQ-002 SHALL have parameter W, default 8: pattern register width in bits.
REQ-003 SHALL have port CLOCK_50  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  level input; only its rising edge launches a frame.
REQ-006 SHALL have port rep  in  1  repeat mode; 1 means frames repeat, separated by gaps.
REQ-007 SHALL have port pat  in  W  pattern to send, MSB first.
REQ-008 SHALL have port len  in  4  bits per frame, 1..W; 0 or any value > W means W.
REQ-009 SHALL have port x  out  1  serial bit stream, the same signal the sequence detector consumes.
REQ-010 SHALL have port bit_tick  out  1  one-cycle pulse on the first cycle of every transmitted bit.
REQ-011 SHALL have port busy  out  1  high in LOAD, SEND and GAP.
REQ-012 SHALL have port done  out  1  one-cycle pulse when a non-repeating frame ends.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SEND and GAP.
REQ-014 SHALL register start into start_d each cycle; a rising edge is start=1 and start_d=0.
REQ-015 SHALL, in IDLE on a rising edge, go to LOAD; all other start activity SHALL be ignored.
REQ-016 SHALL, in LOAD (exactly 1 cycle), capture pat and the effective len into shadow registers, clear the bit index and divider, then go to SEND.
REQ-017 SHALL, in SEND, drive x with shadow bit [W-1-index] and hold each bit exactly DIV cycles.
REQ-018 SHALL raise bit_tick in the first SEND cycle of each bit; a frame of n bits gives exactly n ticks.
REQ-019 SHALL place the first bit on x 2 cycles after the clock edge that samples the start rising edge.
REQ-020 SHALL, after the last bit's DIV cycles with rep=1, go to GAP.
REQ-021 SHALL, after the last bit's DIV cycles with rep=0, pulse done for 1 cycle and go to IDLE.
REQ-022 SHALL, in GAP, drive x=0 for DIV cycles, then go to LOAD, re-sampling pat and len.
REQ-023 SHALL, if rep falls during SEND, finish the current frame and then take the rep=0 path.
REQ-024 SHALL, if rep falls during GAP, pulse done at the end of GAP and go to IDLE.
REQ-025 SHALL ignore changes on pat and len during SEND; they take effect only at the next LOAD.
REQ-026 SHALL size the divider counter as clog2(DIV) bits and the index as clog2(W)+1 bits, and neither SHALL wrap inside a frame.
REQ-027 SHALL hold x=0 in IDLE and GAP.

Reset
REQ-028 SHALL, on rst, immediately force state=IDLE, x=0, bit_tick=0, busy=0, done=0, start_d=0, and clear the counters and shadows.
REQ-029 SHALL, on rst asserted mid-frame, abort the frame with no done pulse; after release it SHALL wait for a new start rising edge.
REQ-030 SHALL treat start held high across reset release as no edge, because start_d resets to 0 and the FSM then waits 1 cycle.

Structure
REQ-031 SHALL put the state encoding constants (IDLE=0, LOAD=1, SEND=2, GAP=3) in shared package seq_pkg.
REQ-032 SHALL put the default DIV in seq_pkg, so the detector bench and this generator agree on bit rate.
REQ-033 SHALL use one sub-module, bit_timer: a DIV-cycle counter with clear input and terminal-count pulse, used in both SEND and GAP.
REQ-034 SHALL keep all other logic in seq_gen, with a single always block for the FSM.

Verification (DIV=4, W=8)
REQ-035 SHALL cover: pat=8'b1001_0000, len=5, rep=0, start pulse -> x=1,0,0,1,0, each bit 4 cycles; 5 bit_ticks; done pulses once; busy high for 21 cycles.
REQ-036 SHALL cover: len=0, pat=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1 are sent; done follows the 32nd SEND cycle.
REQ-037 SHALL cover: rep=1, pat=8'b1001_0000, len=5 -> frame, 4-cycle x=0 gap, frame again; rep dropped in frame 2 -> frame 2 completes, done pulses once.
REQ-038 SHALL cover: pat changed to 8'hFF during SEND -> current frame unchanged; the next repeated frame sends 1s.
REQ-039 SHALL cover: rst pulsed at bit 3 -> x=0 and busy=0 in the same cycle; no done; start held high afterwards -> no new frame until start toggles.
REQ-040 SHALL cover: the generator driving the sequence detector, clocked on bit_tick, with pattern 10010 -> the detector's active-low z asserts on the 5th bit.
